// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// The PC register addresses instruction memory directly. Each fetched word is
// queued together with its address in a small FIFO, and downstream consumes
// the queue head. A redirect flushes the queue and restarts fetch.
// Optional feature: define FETCH_BRANCH_FOLD_EN to fold unconditional
// B (0xEA) branches in the fetch stage. A folded branch is retargeted
// without being queued.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_q, pc_d;

  logic               full;
  logic               fetch_ok;
  logic               is_branch;
  logic               push;
  logic               fold;
  logic               pop;
  logic [31:0]        branch_target;

  // Decode this cycle's fetch, fold and pop decisions; redirect blocks all of them.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latch).
    is_branch     = 1'b0;
    branch_target = pc_q + 32'd4;
`ifdef FETCH_BRANCH_FOLD_EN
    is_branch     = (imem_rd[31:24] == 8'hEA);
    branch_target = pc_q + 32'd8 + {{6{imem_rd[23]}}, imem_rd[23:0], 2'b00};
`endif
    full     = (count_q == CNT_W'(DEPTH));
    fetch_ok = !full && !redirect_valid;
    push     = fetch_ok && !is_branch;
    fold     = fetch_ok && is_branch;
    pop      = (count_q != '0) && inst_ready && !redirect_valid;
  end

  // Compute next PC, pointers and occupancy.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fold) begin
        pc_d = branch_target;
      end else if (push) begin
        pc_d = pc_q + 32'd4;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: write the fetched word and its address at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is cleared on reset because the head entry drives inst/inst_pc, which must read 0 after reset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[tail_q] <= '{pc: pc_q, word: imem_rd};
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst       = mem_q[head_q].word;
  assign inst_pc    = mem_q[head_q].pc;

endmodule
